// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 digest AXI4-Stream serializer.
//   keccak_state_t   : 5x5 array of 64-bit lanes, lane k = state[k%5][k/5]
//   DIGEST_BYTES     : digest length in bytes for TID 0..3 (224/256/384/512)
//   FULL_STATE_BYTES : byte length of a full Keccak-f[1600] state
//   state_t          : serializer FSM states
//   beats()          : number of bus beats needed for n bytes at bpb bytes/beat
package sha3_pkg;

  typedef logic [4:0][4:0][63:0] keccak_state_t;

  localparam int unsigned FULL_STATE_BYTES = 200;
  localparam int unsigned DIGEST_BYTES [4] = '{28, 32, 48, 64};

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic int unsigned beats(input int unsigned n, input int unsigned bpb);
    return (n + bpb - 1) / bpb;
  endfunction

endpackage

// File: rtl/sha3_beat_extract.sv
// Combinational beat selector for the SHA3 serializer.
//   state    : flattened 1600-bit state, stream byte b at state[8*b+7:8*b]
//   beat_idx : beat number within the message
//   beat     : DATA_WIDTH/8 consecutive stream bytes starting at beat_idx*BPB;
//              byte 0 of the beat lands in the low lane, or the high lane when
//              BYTE_SWAP=1. Bytes past the end of the state read as zero.
module sha3_beat_extract
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          BYTE_SWAP  = 1'b0
) (
  input  logic [1599:0]           state,
  input  logic [7:0]              beat_idx,
  output logic [DATA_WIDTH-1:0]   beat
);

  localparam int unsigned BPB = DATA_WIDTH / 8;

  always_comb begin
    beat = '0;
    for (int unsigned j = 0; j < BPB; j++) begin
      if (32'(beat_idx) * BPB + j < FULL_STATE_BYTES)
        beat[8*(BYTE_SWAP ? BPB-1-j : j) +: 8] = state[8*(32'(beat_idx)*BPB + j) +: 8];
    end
  end

endmodule

// File: rtl/sha3_digest_axis.sv
// Captures a Keccak state on a valid/ready handshake and streams either the
// SHA3 digest (224/256/384/512) or the full 200-byte state as an AXI4-Stream
// master.
//   ACLK, ARESET         : clock, asynchronous active-high reset
//   Din/Din_valid/Din_ready, TID_in, Mode : state capture port
//   M_TDATA/M_TKEEP/M_TLAST/M_TID/M_TVALID/M_TREADY : AXI4-Stream master
module sha3_digest_axis
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          BYTE_SWAP  = 1'b0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  keccak_state_t           Din,
  input  logic                    Din_valid,
  output logic                    Din_ready,
  input  logic [1:0]              TID_in,
  input  logic                    Mode,
  output logic [DATA_WIDTH-1:0]   M_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_TKEEP,
  output logic                    M_TLAST,
  output logic [1:0]              M_TID,
  output logic                    M_TVALID,
  input  logic                    M_TREADY
);

  localparam int unsigned BPB = DATA_WIDTH / 8;

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("sha3_digest_axis: DATA_WIDTH must be 8, 16, 32 or 64");
  end

  state_t          state_q;
  logic [1599:0]   st_q;
  logic [7:0]      cnt_q;
  logic [7:0]      total_q;
  logic [BPB-1:0]  last_keep_q;

  logic [1599:0]   din_flat;
  logic [1599:0]   ext_state;
  logic [7:0]      ext_idx;
  logic [DATA_WIDTH-1:0] ext_beat;

  logic [7:0]      msg_bytes;
  logic [7:0]      rem_bytes;
  logic [7:0]      cap_total;
  logic [BPB-1:0]  cap_keep;

  logic            next_last;
  logic [BPB-1:0]  next_keep;
  logic [DATA_WIDTH-1:0] next_data;

  assign Din_ready = (state_q == IDLE) && !ARESET;

  always_comb begin
    din_flat = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      for (int unsigned y = 0; y < 5; y++) begin
        din_flat[64*(5*y + x) +: 64] = Din[x][y];
      end
    end
  end

  always_comb begin
    msg_bytes = Mode ? 8'(FULL_STATE_BYTES) : 8'(DIGEST_BYTES[TID_in]);
    rem_bytes = 8'(32'(msg_bytes) % BPB);
    cap_total = 8'(beats(32'(msg_bytes), BPB));
    cap_keep  = '0;
    for (int unsigned j = 0; j < BPB; j++) begin
      cap_keep[j] = (rem_bytes == 8'd0) || (j < 32'(rem_bytes));
    end
  end

  // The output stage is fully registered, so beat 0 has to be formed from
  // the live Din on the capture edge; afterwards the stored state supplies
  // the beat that follows the one currently on the bus.
  always_comb begin
    if (state_q == IDLE) begin
      ext_state = din_flat;
      ext_idx   = '0;
      next_last = (cap_total == 8'd1);
      next_keep = next_last ? cap_keep : '1;
    end else begin
      ext_state = st_q;
      ext_idx   = cnt_q + 8'd1;
      next_last = (ext_idx == total_q - 8'd1);
      next_keep = next_last ? last_keep_q : '1;
    end
  end

  sha3_beat_extract #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_SWAP  (BYTE_SWAP)
  ) u_extract (
    .state    (ext_state),
    .beat_idx (ext_idx),
    .beat     (ext_beat)
  );

  // Bytes beyond the message end are forced to zero on the bus.
  always_comb begin
    next_data = '0;
    for (int unsigned l = 0; l < BPB; l++) begin
      next_data[8*l +: 8] = next_keep[(BYTE_SWAP ? BPB-1-l : l) +: 1] ? ext_beat[8*l +: 8] : 8'h00;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      st_q        <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      last_keep_q <= '0;
      M_TVALID    <= 1'b0;
      M_TLAST     <= 1'b0;
      M_TDATA     <= '0;
      M_TKEEP     <= '0;
      M_TID       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Din_valid) begin
            st_q        <= din_flat;
            M_TID       <= TID_in;
            total_q     <= cap_total;
            last_keep_q <= cap_keep;
            cnt_q       <= '0;
            M_TVALID    <= 1'b1;
            M_TDATA     <= next_data;
            M_TKEEP     <= next_keep;
            M_TLAST     <= next_last;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (M_TREADY) begin
            if (M_TLAST) begin
              M_TVALID <= 1'b0;
              M_TLAST  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              cnt_q   <= ext_idx;
              M_TDATA <= next_data;
              M_TKEEP <= next_keep;
              M_TLAST <= next_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha3_digest_axis.md
Name: sha3_digest_axis

Overview:
- Parametrised successor to the Keccak state serializer.
- Captures a 1600-bit Keccak state on a valid/ready handshake.
- Streams either the SHA3 digest (224/256/384/512) or the full state as an AXI4-Stream master with backpressure, TKEEP and TLAST.
- Sits between the permutation core and the AXI DMA/stream fabric.

Parameters:
- DATA_WIDTH, 16, TDATA width in bits; legal values 8, 16, 32, 64 (elaboration error otherwise).
- BYTE_SWAP, 0, 0: byte 0 of a beat in TDATA[7:0]; 1: byte 0 in TDATA[DATA_WIDTH-1:DATA_WIDTH-8].

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- Din  in  [4:0][4:0][63:0]  Keccak state; lane k = Din[k%5][k/5].
- Din_valid  in  1  state/TID/Mode valid.
- Din_ready  out  1  block can capture.
- TID_in  in  2  0=224, 1=256, 2=384, 3=512.
- Mode  in  1  0=digest only, 1=full 200-byte state.
- M_TDATA  out  DATA_WIDTH  output beat.
- M_TKEEP  out  DATA_WIDTH/8  byte enables.
- M_TLAST  out  1  final beat of the message.
- M_TID  out  2  TID_in captured with the state.
- M_TVALID  out  1  beat valid.
- M_TREADY  in  1  sink ready.

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counter=0, M_TVALID=0, M_TLAST=0, M_TDATA=0, M_TKEEP=0, M_TID=0. Din_ready=0 while ARESET=1.
- Byte stream order: byte b = lane (b/8) bits [8*(b%8)+7 : 8*(b%8)], i.e. FIPS 202 little-endian lane order. No per-lane swap beyond BYTE_SWAP.
- Message length N bytes: Mode=1 -> 200; Mode=0 -> 28/32/48/64 for TID 0..3.
- BPB = DATA_WIDTH/8. Beats = ceil(N/BPB).
- FSM states: IDLE, STREAM.
- IDLE:
  - Din_ready=1.
  - On Din_valid&Din_ready at edge E: register all 1600 bits, TID, beat total and last-beat keep; go to STREAM.
  - Beat 0 is presented with M_TVALID=1 from E+1 (one-cycle latency).
- STREAM:
  - Din_ready=0; Din_valid ignored.
  - M_TVALID held at 1 until the handshake. TDATA/TKEEP/TLAST/TID stable while M_TREADY=0.
  - On handshake of a non-final beat: the next beat is presented the following cycle, with no bubble.
  - On handshake of the final beat (M_TLAST=1): M_TVALID=0 and M_TLAST=0 next cycle, return to IDLE. Next capture is possible that same IDLE cycle.
- TKEEP: all ones except on the final beat when N%BPB!=0. Final-beat keep = (1<<(N%BPB))-1. Only case: 224 with DATA_WIDTH=64 -> 8'h0F. Unused bytes of that beat are driven 0.
- Beat counter is 8 bits (max 200 beats at DATA_WIDTH=8). Clears to 0 on capture. No wrap occurs.
- Single-beat messages do not occur (min 28 bytes / 8 = 4 beats).
- ARESET asserted mid-stream: M_TVALID drops asynchronously and the message is abandoned. No partial TLAST is emitted. The captured state is not preserved.
- Din is sampled only at the capture edge; later changes to Din have no effect on the message in flight.

Decomposition:
- Package sha3_pkg:
  - keccak_state_t typedef for [4:0][4:0][63:0].
  - Digest-byte constant array {28,32,48,64}.
  - FULL_STATE_BYTES=200.
  - FSM enum {IDLE, STREAM}.
  - Function beats(N, BPB).
- Sub-module sha3_beat_extract (combinational):
  - Inputs: flattened 1600-bit state, beat index, BYTE_SWAP.
  - Output: one DATA_WIDTH beat.
- Top level keeps the FSM, counter and output registers.

Test Plan:
- DATA_WIDTH=16, TID=1, Mode=0, TREADY=1, lane0=64'h0706050403020100 -> 16 beats on consecutive cycles from capture+1; beat0 TDATA=16'h0100; TLAST only on beat 15; TKEEP=2'b11 throughout; TID=1.
- DATA_WIDTH=64, TID=0, Mode=0 -> 4 beats; TKEEP=8'hFF,8'hFF,8'hFF,8'h0F; beat 3 TDATA[63:32]=0; TLAST on beat 3.
- DATA_WIDTH=32, Mode=1, lane24=64'hAABBCCDD11223344 -> 50 beats; beat 48=32'h11223344; beat 49=32'hAABBCCDD with TLAST.
- Backpressure: DATA_WIDTH=16, TID=3, TREADY pattern 1,0,0,1,0,1... -> 32 beats total, none lost or duplicated; TDATA held during stalls; Din_valid pulses during STREAM ignored with Din_ready=0.
- ARESET pulse (half cycle, asynchronous) at beat 5 of 16 -> M_TVALID=0 before the next edge; after release, Din_ready=1; a new capture restarts at beat 0 with the new Din.
- BYTE_SWAP=1, DATA_WIDTH=32, lane0=64'h0706050403020100 -> beat0 TDATA=32'h00010203, beat1=32'h04050607.
